memro_arbiter: RTL and testbench
================================

MEMRO_ARBITER -- requirements
Module: memro_arbiter

Interface
REQ-001 SHALL have parameter WIDTH_DATA, default 32: word width of the shared read-only memory.
REQ-002 SHALL have parameter WIDTH_ADDR, default 16: word-address width of the shared memory.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports req0/req1  input  1  read request from requester 0/1.
REQ-006 SHALL have ports addr0/addr1  input  WIDTH_ADDR  read address from requester 0/1.
REQ-007 SHALL have ports gnt0/gnt1  output  1  combinational grant; request is accepted in any cycle where reqN && gntN.
REQ-008 SHALL have ports rvalid0/rvalid1  output  1  one-cycle pulse: read data for requester 0/1 is valid.
REQ-009 SHALL have ports rdata0/rdata1  output  WIDTH_DATA  read data for requester 0/1; holds its last value between pulses.
REQ-010 SHALL have port mem_re  output  1  memory read enable.
REQ-011 SHALL have port mem_addr  output  WIDTH_ADDR  memory address.
REQ-012 SHALL have port mem_data  input  WIDTH_DATA  memory read data, valid one cycle after mem_re is sampled high.

Function
REQ-013 SHALL grant at most one requester per cycle; gnt0 && gnt1 never both high.
REQ-014 SHALL drive mem_re = (req0&&gnt0)||(req1&&gnt1) and mem_addr = addr of the granted port, else 0, combinationally in the same cycle.
REQ-015 SHALL arbitrate round-robin: pointer last_gnt (1 bit) names the last-served port; when both request, the other port wins.
REQ-016 SHALL grant a sole requester immediately, regardless of last_gnt.
REQ-017 SHALL update last_gnt only in a cycle where a grant is accepted.
REQ-018 SHALL track an in-flight tag (pend_vld, pend_id) registered on every accepted grant and cleared in cycles with no grant.
REQ-019 SHALL, in the cycle after an accepted grant for port N, assert rvalidN for exactly one cycle and load rdataN from mem_data in the same cycle; rdataN becomes visible the following cycle only if registered. Fixed latency: rvalidN and rdataN are both combinationally valid exactly 1 cycle after the grant, with rdataN registered-and-held by a capture register updated on that edge.
REQ-020 SHALL support back-to-back grants every cycle (full throughput, no bubble), including alternating ports.
REQ-021 SHALL never assert rvalid for a port that was not granted in the previous cycle.
REQ-022 SHALL keep rdataN unchanged when rvalidN is low, even though the memory returns 0 when not read.

Reset
REQ-023 SHALL, while rst is high, force gnt0=gnt1=0, mem_re=0, mem_addr=0, rvalid0=rvalid1=0, rdata0=rdata1=0, pend_vld=0, last_gnt=1 (so port 0 wins the first contention).
REQ-024 SHALL discard any in-flight read when rst asserts mid-operation; no rvalid pulse follows the reset release.
REQ-025 SHALL accept requests in the first clock edge after rst deasserts.

Configuration
REQ-026 SHALL, with macro MEMRO_ARB_FIXED_PRIO_EN defined, use fixed priority: port 0 always wins contention, and last_gnt is not implemented.
REQ-027 SHALL, without MEMRO_ARB_FIXED_PRIO_EN, use the round-robin policy of REQ-015..REQ-017.

Verification
REQ-028 SHALL cover: after reset, req0=1 addr0=0x0010 alone -> gnt0=1, mem_re=1, mem_addr=0x0010; next cycle rvalid0=1, rdata0=mem[0x0010].
REQ-029 SHALL cover: req0=req1=1 held for 4 cycles, addr0=0x0001, addr1=0x0002 -> grants 0,1,0,1; rvalid alternates 0,1,0,1 one cycle later, with correct data.
REQ-030 SHALL cover: req1 only for 3 cycles, then both -> grants 1,1,1,0 (first contention goes to port 0).
REQ-031 SHALL cover: single read on port 1, then 5 idle cycles -> rdata1 holds mem value, rvalid1 low throughout idle, mem_re=0.
REQ-032 SHALL cover: rst asserted in the cycle after gnt0 -> rvalid0 stays 0, rdata0=0, and no pulse occurs after release.
REQ-033 SHALL cover: with MEMRO_ARB_FIXED_PRIO_EN, both requesting for 4 cycles -> gnt0 every cycle, gnt1 never.

Source files
------------

// File: rtl/memro_arbiter.sv
// memro_arbiter: two requesters share one read-only memory with a 1-cycle
// synchronous read latency.
//
// Ports:
//   clk, rst          - clock; asynchronous active-high reset
//   req0/1, addr0/1   - read requests; accepted when reqN && gntN
//   gnt0/1            - combinational grants, never both high
//   rvalid0/1         - one-cycle pulse, the cycle after the accepted grant
//   rdata0/1          - read data; shows mem_data during the pulse and
//                       holds the captured value afterwards
//   mem_re, mem_addr  - memory read strobe/address, driven in the grant cycle
//   mem_data          - memory data, valid the cycle after mem_re
//
// Build option: MEMRO_ARB_FIXED_PRIO_EN selects fixed priority, where port 0
// always wins. Without it, arbitration is round-robin on a last_gnt pointer.
module memro_arbiter #(
  parameter int WIDTH_DATA = 32,
  parameter int WIDTH_ADDR = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic [WIDTH_ADDR-1:0] addr0,
  input  logic [WIDTH_ADDR-1:0] addr1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [WIDTH_DATA-1:0] rdata0,
  output logic [WIDTH_DATA-1:0] rdata1,
  output logic                  mem_re,
  output logic [WIDTH_ADDR-1:0] mem_addr,
  input  logic [WIDTH_DATA-1:0] mem_data
);

  logic                  accept;
  logic                  pend_vld;
  logic                  pend_id;   // port of the in-flight read
  logic [WIDTH_DATA-1:0] rdata0_q;
  logic [WIDTH_DATA-1:0] rdata1_q;

`ifdef MEMRO_ARB_FIXED_PRIO_EN
  assign gnt0 = !rst && req0;
  assign gnt1 = !rst && req1 && !req0;
`else
  // last_gnt names the last-served port; on contention the other one wins.
  // Its reset value is 1, so port 0 wins the first contention.
  logic last_gnt;

  assign gnt0 = !rst && req0 && (!req1 || last_gnt);
  assign gnt1 = !rst && req1 && (!req0 || !last_gnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         last_gnt <= 1'b1;
    else if (accept) last_gnt <= gnt1;
  end
`endif

  // A grant is only ever given to a port that is requesting, so any grant
  // is also an accept.
  assign accept   = gnt0 || gnt1;
  assign mem_re   = accept;
  assign mem_addr = gnt0 ? addr0 : (gnt1 ? addr1 : '0);

  // The in-flight tag lasts exactly one cycle, which gives the fixed
  // 1-cycle response latency. It is cleared in any cycle with no grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_vld <= 1'b0;
      pend_id  <= 1'b0;
    end else begin
      pend_vld <= accept;
      pend_id  <= gnt1;
    end
  end

  assign rvalid0 = pend_vld && !pend_id;
  assign rvalid1 = pend_vld &&  pend_id;

  // mem_data is only meaningful in the pulse cycle (the memory returns 0
  // otherwise). It is forwarded live during the pulse and captured on the
  // closing edge, so the read data stays stable between pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (rvalid0) rdata0_q <= mem_data;
      if (rvalid1) rdata1_q <= mem_data;
    end
  end

  assign rdata0 = rvalid0 ? mem_data : rdata0_q;
  assign rdata1 = rvalid1 ? mem_data : rdata1_q;

endmodule

// File: tb/tb_memro_arbiter.sv
module tb_memro_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [15:0] addr0 = '0, addr1 = '0;
  logic        gnt0, gnt1, rvalid0, rvalid1, mem_re;
  logic [31:0] rdata0, rdata1, mem_data;
  logic [15:0] mem_addr;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  memro_arbiter #(.WIDTH_DATA(32), .WIDTH_ADDR(16)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_re(mem_re), .mem_addr(mem_addr), .mem_data(mem_data)
  );

  // Memory contents: word = {addr, addr ^ A5A5}.
  function automatic logic [31:0] memf(input logic [15:0] a);
    return {a, a ^ 16'hA5A5};
  endfunction

  // Synchronous-read ROM; it returns 0 in any cycle it is not read.
  always @(posedge clk) mem_data <= mem_re ? memf(mem_addr) : 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Arbitration rule: returns {gnt1, gnt0}.
  function automatic logic [1:0] arb(input logic r0, input logic r1, input logic last);
    if (r0 && !r1) return 2'b01;
    if (r1 && !r0) return 2'b10;
    if (!r0 && !r1) return 2'b00;
`ifdef MEMRO_ARB_FIXED_PRIO_EN
    return 2'b01;
`else
    return last ? 2'b01 : 2'b10;
`endif
  endfunction

  logic        m_last = 1'b1;  // last-served port
  logic        m_pv   = 1'b0;  // a response is due this cycle
  logic        m_pid  = 1'b0;
  logic [15:0] m_paddr = '0;
  logic [31:0] m_rd0 = '0, m_rd1 = '0;  // last delivered data per port

  always @(posedge clk) begin
    logic [1:0] g;
    g = arb(req0, req1, m_last);
    if (rst) begin
      m_last <= 1'b1; m_pv <= 1'b0; m_pid <= 1'b0; m_rd0 <= '0; m_rd1 <= '0;
    end else begin
      if (m_pv && !m_pid) m_rd0 <= memf(m_paddr);
      if (m_pv &&  m_pid) m_rd1 <= memf(m_paddr);
      m_pv    <= |g;
      m_pid   <= g[1];
      m_paddr <= g[0] ? addr0 : addr1;
      if (|g) m_last <= g[1];
    end
  end

  // Compare process: outputs checked mid-cycle, on every cycle.
  always @(negedge clk) begin
    logic [1:0]  g;
    logic        e_rv0, e_rv1;
    logic [31:0] e_rd0, e_rd1;
    logic [15:0] e_addr;
    if (rst) begin
      g = 2'b00; e_rv0 = 0; e_rv1 = 0; e_rd0 = '0; e_rd1 = '0;
    end else begin
      g = arb(req0, req1, m_last);
      e_rv0 = m_pv && !m_pid;
      e_rv1 = m_pv &&  m_pid;
      e_rd0 = e_rv0 ? memf(m_paddr) : m_rd0;
      e_rd1 = e_rv1 ? memf(m_paddr) : m_rd1;
    end
    e_addr = g[0] ? addr0 : (g[1] ? addr1 : 16'h0);
    chk("gnt0", {31'b0, gnt0}, {31'b0, g[0]});
    chk("gnt1", {31'b0, gnt1}, {31'b0, g[1]});
    chk("mem_re", {31'b0, mem_re}, {31'b0, |g});
    chk("mem_addr", {16'b0, mem_addr}, {16'b0, e_addr});
    chk("rvalid0", {31'b0, rvalid0}, {31'b0, e_rv0});
    chk("rvalid1", {31'b0, rvalid1}, {31'b0, e_rv1});
    chk("rdata0", rdata0, e_rd0);
    chk("rdata1", rdata1, e_rd1);
  end

  // ---------------- stimulus ----------------
  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    next_cycle();
    rst = 1'b1; req0 = 0; req1 = 0;
    next_cycle();
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_g1;
    exp_g1 = 4'b0111;  // bit i = expected gnt1 in cycle i of the req1-then-both test

    // Reset state with a request already pending.
    repeat (2) next_cycle();
    req0 = 1'b1; addr0 = 16'h0010;
    @(negedge clk);
    chk("rst_gnt0", {31'b0, gnt0}, 32'd0);
    chk("rst_mem_re", {31'b0, mem_re}, 32'd0);
    chk("rst_rdata0", rdata0, 32'h0);
    // The first edge after release accepts the request.
    next_cycle(); rst = 1'b0;
    @(negedge clk);
    chk("first_gnt0", {31'b0, gnt0}, 32'd1);
    chk("first_mem_addr", {16'b0, mem_addr}, 32'h0010);
    next_cycle(); req0 = 1'b0;
    @(negedge clk);
    chk("first_rvalid0", {31'b0, rvalid0}, 32'd1);
    chk("first_rdata0", rdata0, 32'h0010_A5B5);

`ifndef MEMRO_ARB_FIXED_PRIO_EN
    // Contention: grants alternate 0,1,0,1; responses follow one cycle later.
    do_reset();
    req0 = 1; req1 = 1; addr0 = 16'h0001; addr1 = 16'h0002;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rr_gnt0", {31'b0, gnt0}, {31'b0, (i % 2) == 0});
      if (i > 0) begin
        chk("rr_rvalid0", {31'b0, rvalid0}, {31'b0, (i % 2) == 1});
        chk("rr_rdata", (i % 2) ? rdata0 : rdata1, (i % 2) ? 32'h0001_A5A4 : 32'h0002_A5A7);
      end
      next_cycle();
    end
    req0 = 0; req1 = 0;
    @(negedge clk);
    chk("rr_last_rvalid1", {31'b0, rvalid1}, 32'd1);
    chk("rr_last_rdata1", rdata1, 32'h0002_A5A7);
`endif

    // req1 alone for three cycles, then both: grants 1,1,1,0.
    do_reset();
    req1 = 1; addr1 = 16'h0002; addr0 = 16'h0001;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("sole_gnt1", {31'b0, gnt1}, {31'b0, exp_g1[i]});
      next_cycle();
      if (i == 2) req0 = 1;
    end
    req0 = 0; req1 = 0;

    // Single port-1 read, then idle: data holds, no pulses, no reads.
    do_reset();
    req1 = 1; addr1 = 16'h0002;
    next_cycle(); req1 = 0;
    @(negedge clk);
    chk("hold_rvalid1", {31'b0, rvalid1}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      @(negedge clk);
      chk("idle_rvalid1", {31'b0, rvalid1}, 32'd0);
      chk("idle_mem_re", {31'b0, mem_re}, 32'd0);
      chk("idle_rdata1", rdata1, 32'h0002_A5A7);
    end

    // Reset lands while a read is in flight: the response is dropped.
    do_reset();
    req0 = 1; addr0 = 16'h0010;
    @(negedge clk);
    chk("abort_gnt0", {31'b0, gnt0}, 32'd1);
    next_cycle(); req0 = 0; rst = 1;
    @(negedge clk);
    chk("abort_rvalid0", {31'b0, rvalid0}, 32'd0);
    chk("abort_rdata0", rdata0, 32'h0);
    next_cycle(); rst = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_after_rvalid0", {31'b0, rvalid0}, 32'd0);
      next_cycle();
    end

`ifdef MEMRO_ARB_FIXED_PRIO_EN
    do_reset();
    req0 = 1; req1 = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("fixed_gnt0", {31'b0, gnt0}, 32'd1);
      chk("fixed_gnt1", {31'b0, gnt1}, 32'd0);
      next_cycle();
    end
    req0 = 0; req1 = 0;
`endif

    // Randomized traffic with occasional resets; the model checks every cycle.
    for (int i = 0; i < 600; i++) begin
      next_cycle();
      rst   = ($urandom_range(0, 59) == 0);
      req0  = ($urandom_range(0, 3) != 0);
      req1  = ($urandom_range(0, 3) != 0);
      addr0 = 16'($urandom);
      addr1 = 16'($urandom);
    end
    next_cycle();
    rst = 0; req0 = 0; req1 = 0;
    repeat (3) next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
